// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchroniser, mid-bit sampling and stop-bit check.
// Define UART_RX_PARITY_EN to add a parity bit (8 data + parity + stop) with parity-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY_ODD   = 0
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          r_State;
    logic [1:0]      r_Sync;
    logic [CW-1:0]   r_Cnt;
    logic [2:0]      r_Idx;
    logic [7:0]      r_Shift;
    logic [7:0]      r_Byte;
    logic            r_DV;
    logic            r_Frame_Err;
    logic            w_Rx_S;
    logic            w_Bit_End;
`ifdef UART_RX_PARITY_EN
    logic            r_Par_Bad;
    logic            r_Parity_Err;
`endif

    assign w_Rx_S    = r_Sync[1];
    assign w_Bit_End = (r_Cnt == LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_State     <= S_IDLE;
            r_Sync      <= 2'b11;
            r_Cnt       <= '0;
            r_Idx       <= '0;
            r_Shift     <= '0;
            r_Byte      <= '0;
            r_DV        <= 1'b0;
            r_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Par_Bad    <= 1'b0;
            r_Parity_Err <= 1'b0;
`endif
        end else begin
            r_Sync      <= {r_Sync[0], i_RX_Serial};
            r_DV        <= 1'b0;
            r_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_Parity_Err <= 1'b0;
`endif
            case (r_State)
                S_IDLE: begin
                    r_Cnt <= '0;
                    r_Idx <= '0;
`ifdef UART_RX_PARITY_EN
                    r_Par_Bad <= 1'b0;
`endif
                    if (!w_Rx_S) r_State <= S_START;
                end
                S_START: begin
                    // Re-check the line at mid start bit to reject short glitches
                    if (r_Cnt == HALF) begin
                        r_Cnt   <= '0;
                        r_State <= w_Rx_S ? S_IDLE : S_DATA;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_Bit_End) begin
                        r_Cnt          <= '0;
                        r_Shift[r_Idx] <= w_Rx_S;
                        r_Idx          <= r_Idx + 3'd1;
                        if (r_Idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_State <= S_PARITY;
`else
                            r_State <= S_STOP;
`endif
                        end
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_Bit_End) begin
                        r_Cnt     <= '0;
                        r_Par_Bad <= (w_Rx_S != ((^r_Shift) ^ (PARITY_ODD != 0)));
                        r_State   <= S_STOP;
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_Bit_End) begin
                        r_Cnt <= '0;
                        if (w_Rx_S) begin
`ifdef UART_RX_PARITY_EN
                            if (r_Par_Bad) begin
                                r_Parity_Err <= 1'b1;
                            end else begin
                                r_Byte <= r_Shift;
                                r_DV   <= 1'b1;
                            end
`else
                            r_Byte <= r_Shift;
                            r_DV   <= 1'b1;
`endif
                            r_State <= S_IDLE;
                        end else begin
                            r_Frame_Err <= 1'b1;
                            r_State     <= S_BREAK;
                        end
                    end else begin
                        r_Cnt <= r_Cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // Held-low line must go high before a new start bit can count
                    if (w_Rx_S) r_State <= S_IDLE;
                end
                default: r_State <= S_IDLE;
            endcase
        end
    end

    assign o_RX_DV        = r_DV;
    assign o_RX_Byte      = r_Byte;
    assign o_RX_Frame_Err = r_Frame_Err;
    assign o_RX_Active    = (r_State == S_START) || (r_State == S_DATA) ||
                            (r_State == S_PARITY) || (r_State == S_STOP);
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = r_Parity_Err;
`else
    // Always 0 without parity; the term only keeps PARITY_ODD referenced
    assign o_RX_Parity_Err = 1'b0 && (PARITY_ODD != 0);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + random frames for uart_rx (CLKS_PER_BIT=8), checked against
// a frame-level outcome model (DV / frame error / parity error, last good byte).
module tb_uart_rx;
    localparam int N   = 8;
    localparam int H   = (N - 1) / 2;
    localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       o_RX_DV, o_RX_Active, o_RX_Frame_Err, o_RX_Parity_Err;
    logic [7:0] o_RX_Byte;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N), .PARITY_ODD(ODD)) dut (
        .i_Clock        (clk),
        .i_Rst          (rst),
        .i_RX_Serial    (rx),
        .o_RX_DV        (o_RX_DV),
        .o_RX_Byte      (o_RX_Byte),
        .o_RX_Active    (o_RX_Active),
        .o_RX_Frame_Err (o_RX_Frame_Err),
        .o_RX_Parity_Err(o_RX_Parity_Err)
    );

    int         n_asrt = 0;
    int         n_fail = 0;
    int         active_cnt = 0;
    logic [7:0] model_byte = 8'h00;
    // event = {kind, byte}: kind 1=DV, 2=frame err, 3=parity err, 0=overlapping strobes
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    always @(negedge clk) begin
        if (o_RX_Active) active_cnt++;
        if (o_RX_DV || o_RX_Frame_Err || o_RX_Parity_Err) begin
            if (int'(o_RX_DV) + int'(o_RX_Frame_Err) + int'(o_RX_Parity_Err) > 1)
                got_q.push_back({2'd0, o_RX_Byte});
            else if (o_RX_DV)        got_q.push_back({2'd1, o_RX_Byte});
            else if (o_RX_Frame_Err) got_q.push_back({2'd2, o_RX_Byte});
            else                     got_q.push_back({2'd3, o_RX_Byte});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(N);
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return (^b) ^ (ODD != 0);
    endfunction

    // Drives one frame, then records the outcome the receiver should report.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, input int gap);
        logic par_bad;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(par);
        drive_bit(stop);
        par_bad = PAR_EN && (par != good_par(b));
        if (!stop)        exp_q.push_back({2'd2, model_byte});
        else if (par_bad) exp_q.push_back({2'd3, model_byte});
        else begin
            model_byte = b;
            exp_q.push_back({2'd1, b});
        end
        if (gap > 0) begin
            rx = 1'b1;
            tick(gap);
        end
    endtask

    task automatic check_events(input string tag);
        chk({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, " event"}, got_q[i], exp_q[i]);
        chk({tag, " byte"}, o_RX_Byte, model_byte);
        chk({tag, " idle"}, o_RX_Active, 1'b0);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       s, p;
        int         g;

        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        chk("reset byte", o_RX_Byte, 8'h00);
        chk("reset flags", {o_RX_DV, o_RX_Frame_Err, o_RX_Parity_Err, o_RX_Active}, 4'b0000);
        rst = 1'b0;
        tick(2 * N);

        active_cnt = 0;
        send_frame(8'h55, 1'b1, good_par(8'h55), 2 * N);
        chk("0x55 active cycles", active_cnt, H + 1 + (PAR_EN ? 10 : 9) * N);
        check_events("0x55");

        send_frame(8'h00, 1'b1, good_par(8'h00), 0);
        send_frame(8'hFF, 1'b1, good_par(8'hFF), 2 * N);
        check_events("back2back");

        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(2 * N);
        check_events("glitch");
        send_frame(8'h3C, 1'b1, good_par(8'h3C), 2 * N);
        check_events("0x3C");

        send_frame(8'hA5, 1'b0, good_par(8'hA5), 0);
        tick(20 * N);
        chk("break active", o_RX_Active, 1'b0);
        rx = 1'b1;
        tick(2 * N);
        check_events("break");
        send_frame(8'h81, 1'b1, good_par(8'h81), 2 * N);
        check_events("0x81");

        // Reset pulse in the middle of data bit 4 of 0x96; frame is abandoned
        b = 8'h96;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        tick(N / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        chk("midreset byte", o_RX_Byte, 8'h00);
        chk("midreset flags", {o_RX_DV, o_RX_Frame_Err, o_RX_Parity_Err, o_RX_Active}, 4'b0000);
        rst = 1'b0;
        model_byte = 8'h00;
        tick(2 * N);
        check_events("midreset");
        send_frame(8'h96, 1'b1, good_par(8'h96), 2 * N);
        check_events("0x96");

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b1, 2 * N);
            check_events("par good");
            send_frame(8'h07, 1'b1, 1'b0, 2 * N);
            check_events("par bad");
        end

        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            p = good_par(b) ^ (PAR_EN && ($urandom_range(0, 5) == 0));
            g = s ? $urandom_range(0, 2 * N) : N + $urandom_range(0, N);
            send_frame(b, s, p, g);
            if (g == 0) tick(2);
            check_events("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
